alu_exec_unit: RTL and testbench

//  Consumer end of the 4-bit ALU control code produced by the opcode decoder.

---
 rtl/alu_exec_unit_if.sv | 30 +++
 rtl/alu_exec_unit.sv | 180 ++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the opcode decoder side and the ALU execute unit.
interface alu_exec_unit_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = 4
);
   logic             start;
   logic [3:0]       alu_cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [SHW-1:0]   shamt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             flag_s;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   // Requester: issues ops, observes status and results.
   modport master (
      output start, alu_cnt, op_a, op_b, shamt,
      input  busy, done, result, flag_s, flag_z, flag_c, flag_v
   );

   // Execute unit: accepts ops, returns status and results.
   modport slave (
      input  start, alu_cnt, op_a, op_b, shamt,
      output busy, done, result, flag_s, flag_z, flag_c, flag_v
   );
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execute unit: single-cycle arithmetic/logic ops, iterative one-bit-per-clock shifts,
// start/busy/done handshake with registered result and S/Z/C/V flags.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_exec_unit_if.slave bus
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_MOV = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b1000;
   localparam logic [3:0] OP_SLR = 4'b1001;
   localparam logic [3:0] OP_SRL = 4'b1010;
   localparam logic [3:0] OP_SRA = 4'b1011;
   localparam logic [3:0] OP_IN  = 4'b1100;
   localparam logic [3:0] OP_OUT = 4'b1101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] sh_q;
   logic             sc_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             flag_s_q;
   logic             flag_z_q;
   logic             flag_c_q;
   logic             flag_v_q;

   logic [WIDTH-1:0] sh_nxt_c;
   logic             sc_nxt_c;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   diff_c;
   logic [WIDTH-1:0] res_c;
   logic             c_c;
   logic             v_c;
   logic             start_shift_c;

   // Shift ops with a non-zero amount take the iterative path.
   assign start_shift_c = (bus.alu_cnt[3:2] == 2'b10) && (bus.shamt != '0);

   // One-bit shift/rotate step; carry tracks the bit leaving the word.
   always_comb begin
      sh_nxt_c = sh_q;
      sc_nxt_c = sc_q;
      case (op_q[1:0])
         2'b00: begin
            sh_nxt_c = {sh_q[WIDTH-2:0], 1'b0};
            sc_nxt_c = sh_q[WIDTH-1];
         end
         2'b01: begin
            sh_nxt_c = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
            sc_nxt_c = sh_q[WIDTH-1];
         end
         2'b10: begin
            sh_nxt_c = {1'b0, sh_q[WIDTH-1:1]};
            sc_nxt_c = sh_q[0];
         end
         default: begin
            sh_nxt_c = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            sc_nxt_c = sh_q[0];
         end
      endcase
   end

   // Final result, carry and overflow for the captured op.
   always_comb begin
      sum_c  = {1'b0, a_q} + {1'b0, b_q};
      diff_c = {1'b0, a_q} - {1'b0, b_q};
      res_c  = '0;
      c_c    = 1'b0;
      v_c    = 1'b0;
      case (op_q)
         OP_ADD: begin
            res_c = sum_c[WIDTH-1:0];
            c_c   = sum_c[WIDTH];
            v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_SUB: begin
            res_c = diff_c[WIDTH-1:0];
            c_c   = diff_c[WIDTH];
            v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_c[WIDTH-1] != a_q[WIDTH-1]);
         end
         OP_AND: res_c = a_q & b_q;
         OP_OR:  res_c = a_q | b_q;
         OP_XOR: res_c = a_q ^ b_q;
         OP_MOV: res_c = b_q;
         OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
            res_c = sh_q;
            c_c   = sc_q;
         end
         OP_IN:  res_c = b_q;
         OP_OUT: res_c = a_q;
         default: res_c = '0;
      endcase
   end

   // Control FSM with operand capture, shift iteration and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cnt_q    <= '0;
         sh_q     <= '0;
         sc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         flag_s_q <= 1'b0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.alu_cnt;
                  a_q    <= bus.op_a;
                  b_q    <= bus.op_b;
                  cnt_q  <= bus.shamt;
                  sh_q   <= bus.op_a;
                  sc_q   <= 1'b0;
                  busy_q <= 1'b1;
                  state  <= start_shift_c ? SHIFT : FIN;
               end
            end
            SHIFT: begin
               sh_q  <= sh_nxt_c;
               sc_q  <= sc_nxt_c;
               cnt_q <= cnt_q - SHW'(1);
               if (cnt_q == SHW'(1)) begin
                  state <= FIN;
               end
            end
            FIN: begin
               result_q <= res_c;
               flag_s_q <= res_c[WIDTH-1];
               flag_z_q <= (res_c == '0);
               flag_c_q <= c_c;
               flag_v_q <= v_c;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.flag_s = flag_s_q;
   assign bus.flag_z = flag_z_q;
   assign bus.flag_c = flag_c_q;
   assign bus.flag_v = flag_v_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed spec cases plus randomized ops
// against an arithmetic reference model.
module tb_alu_exec_unit;

   localparam int unsigned W  = 16;
   localparam int unsigned SW = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   alu_exec_unit_if #(.WIDTH(W), .SHW(SW)) bus ();

   alu_exec_unit #(.WIDTH(W), .SHW(SW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Reference: {result[15:0], S, Z, C, V} from plain integer arithmetic.
   function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [3:0] n);
      int ua, ub, sa, sb, r, t;
      logic c, v;
      logic [15:0] rr;
      ua = int'(a);
      ub = int'(b);
      sa = int'(signed'(a));
      sb = int'(signed'(b));
      r = 0; t = 0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0: begin
            t = ua + ub; r = t % 65536; c = (t > 65535);
            v = (sa + sb > 32767) || (sa + sb < -32768);
         end
         4'd1: begin
            r = (ua - ub + 65536) % 65536; c = (ua < ub);
            v = (sa - sb > 32767) || (sa - sb < -32768);
         end
         4'd2: r = ua & ub;
         4'd3: r = ua | ub;
         4'd4: r = ua ^ ub;
         4'd6, 4'd12: r = ub;
         4'd13: r = ua;
         4'd8: begin
            t = ua << n; r = t % 65536; c = (n != 0) && t[16];
         end
         4'd9: begin
            r = ((ua << n) | (ua >> (16 - int'(n)))) % 65536;
            c = (n != 0) && r[0];
         end
         4'd10, 4'd11: begin
            r = (op == 4'd10) ? (ua >> n) : ((sa >>> n) & 65535);
            if (n != 0) begin
               t = ua >> (int'(n) - 1);
               c = t[0];
            end
         end
         default: r = 0;
      endcase
      rr = 16'(r);
      return {rr, rr[15], (rr == 16'h0000), c, v};
   endfunction

   function automatic int exp_lat(input logic [3:0] op, input logic [3:0] n);
      return (op[3:2] == 2'b10 && n != 0) ? int'(n) + 1 : 1;
   endfunction

   // Issue one op at posedge+1 and wait (bounded) for done; returns latency (-1 on timeout).
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] n, output int lat, output logic busy_ok);
      bus.alu_cnt = op; bus.op_a = a; bus.op_b = b; bus.shamt = n; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.alu_cnt = 4'($urandom); bus.op_a = 16'($urandom);
      bus.op_b = 16'($urandom); bus.shamt = 4'($urandom);
      busy_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) begin
            lat = i;
            if (bus.busy !== 1'b0) busy_ok = 1'b0;
            break;
         end else if (bus.busy !== 1'b1) begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      logic [20:0] obs;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.alu_cnt = '0; bus.op_a = '0; bus.op_b = '0; bus.shamt = '0;
      #12;
      obs = {bus.busy, bus.done, bus.result, bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v};
      n_checks++;
      if (obs !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 21'h0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      obs = {bus.busy, bus.done, bus.result, bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v};
      n_checks++;
      if (obs !== 21'h0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got %h expected %h", obs, 21'h0);
      end
   endtask

   task automatic test_directed();
      logic [3:0]  ops [8] = '{4'h0, 4'h1, 4'h1, 4'hB, 4'h9, 4'h8, 4'hE, 4'h6};
      logic [15:0] as  [8] = '{16'h7FFF, 16'h0003, 16'h0005, 16'h8004, 16'h8001, 16'h00F0, 16'hFFFF, 16'hAAAA};
      logic [15:0] bs  [8] = '{16'h0001, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234};
      logic [3:0]  ns  [8] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd4, 4'd0, 4'd0, 4'd3};
      logic [15:0] ers [8] = '{16'h8000, 16'hFFFE, 16'h0000, 16'hE001, 16'h0018, 16'h00F0, 16'h0000, 16'h1234};
      logic [3:0]  efs [8] = '{4'b1001, 4'b1010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      int          els [8] = '{1, 1, 1, 3, 5, 1, 1, 1};
      int lat;
      logic bok;
      logic [3:0] fl;
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], as[i], bs[i], ns[i], lat, bok);
         fl = {bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v};
         n_checks++;
         if (lat != els[i]) begin
            n_fail++;
            $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, els[i]);
         end
         n_checks++;
         if (bus.result !== ers[i]) begin
            n_fail++;
            $display("FAIL directed_%0d_result: got %h expected %h", i, bus.result, ers[i]);
         end
         n_checks++;
         if (fl !== efs[i]) begin
            n_fail++;
            $display("FAIL directed_%0d_flags_szcv: got %b expected %b", i, fl, efs[i]);
         end
         n_checks++;
         if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL directed_%0d_busy: got %b expected %b", i, bok, 1'b1);
         end
      end
   endtask

   task automatic test_ignore_busy();
      int lat = -1;
      int ndone = 0;
      logic [15:0] res = '0;
      logic c = 1'b0;
      bus.alu_cnt = 4'hA; bus.op_a = 16'hFFFF; bus.op_b = 16'h0000; bus.shamt = 4'd15;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 3) begin
            bus.start = 1'b1; bus.alu_cnt = 4'h0; bus.op_a = 16'h0001;
            bus.op_b = 16'h0001; bus.shamt = 4'd0;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.done === 1'b1) begin
            ndone++;
            if (lat < 0) begin
               lat = i; res = bus.result; c = bus.flag_c;
            end
         end
      end
      n_checks++;
      if (lat != 16) begin
         n_fail++;
         $display("FAIL ignore_busy_latency: got %0d expected %0d", lat, 16);
      end
      n_checks++;
      if (ndone != 1) begin
         n_fail++;
         $display("FAIL ignore_busy_done_count: got %0d expected %0d", ndone, 1);
      end
      n_checks++;
      if ({res, c} !== {16'h0001, 1'b1}) begin
         n_fail++;
         $display("FAIL ignore_busy_result_c: got %h/%b expected %h/%b", res, c, 16'h0001, 1'b1);
      end
   endtask

   task automatic test_random();
      int lat;
      logic bok;
      logic [3:0] op, n;
      logic [15:0] a, b;
      logic [19:0] exp, obs;
      int gap;
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom);
         a = 16'($urandom);
         b = 16'($urandom);
         n = 4'($urandom);
         if (i % 7 == 0) a = 16'h8000;
         if (i % 11 == 0) b = a;
         run_op(op, a, b, n, lat, bok);
         exp = model(op, a, b, n);
         obs = {bus.result, bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v};
         n_checks++;
         if (obs !== exp || lat != exp_lat(op, n) || bok !== 1'b1) begin
            n_fail++;
            $display("FAIL random_%0d op=%h a=%h b=%h n=%0d: got res/flags=%h lat=%0d busy_ok=%b expected %h lat=%0d busy_ok=1",
                     i, op, a, b, n, obs, lat, bok, exp, exp_lat(op, n));
         end
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({bus.busy, bus.done, bus.result} !== {2'b00, exp[19:4]}) begin
               n_fail++;
               $display("FAIL random_%0d_idle_hold: got %h expected %h", i,
                        {bus.busy, bus.done, bus.result}, {2'b00, exp[19:4]});
            end
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [20:0] obs;
      int ndone = 0;
      int lat;
      logic bok;
      run_op(4'h3, 16'h0F0F, 16'h5000, 4'd0, lat, bok);
      bus.alu_cnt = 4'h8; bus.op_a = 16'h00FF; bus.op_b = 16'h0000; bus.shamt = 4'd8;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      obs = {bus.busy, bus.done, bus.result, bus.flag_s, bus.flag_z, bus.flag_c, bus.flag_v};
      n_checks++;
      if (obs !== 21'h0) begin
         n_fail++;
         $display("FAIL midop_reset_outputs: got %h expected %h", obs, 21'h0);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 15; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (ndone != 0) begin
         n_fail++;
         $display("FAIL midop_no_done_after_abort: got %0d expected %0d", ndone, 0);
      end
      run_op(4'h0, 16'h0001, 16'h0002, 4'd0, lat, bok);
      n_checks++;
      if ({bus.result, bus.flag_z} !== {16'h0003, 1'b0} || lat != 1) begin
         n_fail++;
         $display("FAIL midop_restart: got %h lat=%0d expected %h lat=1", bus.result, lat, 16'h0003);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_busy();
      test_random();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
